fifo_wr_arbiter: RTL

Shares the single write port of the asynchronous FIFO among NREQ requesters in the write-clock domain.
- Round-robin arbitration with a bounded burst lock per grant.
- Each requester uses a valid/ready handshake; the arbiter drives the FIFO's winc/wdata and obeys wfull.
- Sits directly in front of the FIFO write side and runs on the FIFO's write clock.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter that must hold values up to burst.
  function automatic int cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i.
module fifo_rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic            any_valid_o,
  output logic [IW-1:0]   pick_o
);

  logic [IW:0] idx;

  // Walk the offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    any_valid_o = 1'b0;
    pick_o      = '0;
    idx         = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr_i} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ)) begin
        idx = idx - (IW+1)'(NREQ);
      end
      if (req_i[idx[IW-1:0]]) begin
        any_valid_o = 1'b1;
        pick_o      = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters,
// with a bounded burst per grant and one idle bubble between grants.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [idx_w(NREQ)-1:0]  grant_id,
  output logic                    busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(BURST);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic           any_valid;
  logic [IW-1:0]  pick_idx;
  logic           own_valid;
  logic [DSIZE-1:0] own_data;
  logic           rel;

  fifo_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (any_valid),
    .pick_o      (pick_idx)
  );

  // Select the registered owner's valid and data lanes.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // FIFO-side and requester-side outputs; winc gates on wfull combinationally.
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    busy      = 1'b0;
    grant_id  = owner_q;
    if (state_q == GRANT) begin
      busy  = 1'b1;
      winc  = own_valid & ~wfull;
      wdata = own_data;
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == IW'(i)) begin
          req_ready[i] = ~wfull;
        end
      end
    end
  end

  // Next-state: grant on any request, release on burst end or owner drop.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    rel        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!own_valid) begin
          rel = 1'b1;
        end else if (winc) begin
          if (beat_cnt_q == CW'(BURST - 1)) begin
            rel = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        // wfull with a valid owner: hold everything, grant stays put.
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      rr_ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
